// File: rtl/snd_pkg.sv
// Shared encodings for the sound-bus sequencer: target selects and FSM states.
package snd_pkg;

  localparam logic [1:0] SEL_YM0  = 2'd0;
  localparam logic [1:0] SEL_YM1  = 2'd1;
  localparam logic [1:0] SEL_SAA  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DROP
  } snd_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snd_warmup_timer.sv
// SAA clock-enable register plus warm-up counter; saa_warm rises WARMUP_CYC
// cycles after a 0->1 enable and drops at once on disable.
module snd_warmup_timer #(
  parameter int WARMUP_CYC = 64
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic cfg_we,
  input  logic cfg_saa_en,
  output logic saa_enabled,
  output logic saa_warm
);

  localparam int CW = $clog2(WARMUP_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      saa_enabled <= 1'b0;
      saa_warm    <= 1'b0;
      cnt_q       <= '0;
    end else if (cfg_we && cfg_saa_en && !saa_enabled) begin
      saa_enabled <= 1'b1;
      saa_warm    <= 1'b0;
      cnt_q       <= '0;
    end else if (cfg_we && !cfg_saa_en) begin
      saa_enabled <= 1'b0;
      saa_warm    <= 1'b0;
    end else if (saa_enabled && !saa_warm) begin
      // Rewriting enable=1 lands here, so warm-up keeps counting undisturbed.
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(WARMUP_CYC - 1))
        saa_warm <= 1'b1;
    end
  end

endmodule

// File: rtl/snd_bus_seq.sv
// Sequences queued register writes onto the shared YM2203/YM2203/SAA1099 bus
// with programmable setup/strobe/hold timing; all outputs are registered.
module snd_bus_seq
  import snd_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 2,
  parameter int WARMUP_CYC = 64
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  input  logic       cfg_we,
  input  logic       cfg_saa_en,
  output logic       saa_enabled,
  output logic [7:0] bus_d,
  output logic       bus_a0,
  output logic       ym0_cs_n,
  output logic       ym1_cs_n,
  output logic       saa_cs_n,
  output logic       wr_n,
  output logic       busy
);

  localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  snd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q;
  logic [1:0]       cs_sel;
  logic             accept, load, cs_active;
  logic             saa_warm;

  snd_warmup_timer #(
    .WARMUP_CYC(WARMUP_CYC)
  ) u_warmup (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_saa_en (cfg_saa_en),
    .saa_enabled(saa_enabled),
    .saa_warm   (saa_warm)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_sel)
            SEL_YM0, SEL_YM1: begin
              accept = 1'b1;
              load   = 1'b1;
            end
            SEL_SAA: begin
              // Enabled but still warming up: stall without acknowledging.
              if (saa_warm) begin
                accept = 1'b1;
                load   = 1'b1;
              end else if (!saa_enabled) begin
                accept = 1'b1;
              end
            end
            default: accept = 1'b1;
          endcase
        end
        if (load) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end else if (accept) begin
          state_d = ST_DROP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DROP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  assign cs_sel    = load ? req_sel : sel_q;
  assign cs_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                     (state_d == ST_HOLD);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= SEL_YM0;
      bus_d     <= '0;
      bus_a0    <= 1'b0;
      ym0_cs_n  <= 1'b1;
      ym1_cs_n  <= 1'b1;
      saa_cs_n  <= 1'b1;
      wr_n      <= 1'b1;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= accept;
      busy      <= (state_d != ST_IDLE);
      if (load) begin
        sel_q  <= req_sel;
        bus_d  <= req_data;
        bus_a0 <= req_a0;
      end
      ym0_cs_n <= !(cs_active && (cs_sel == SEL_YM0));
      ym1_cs_n <= !(cs_active && (cs_sel == SEL_YM1));
      saa_cs_n <= !(cs_active && (cs_sel == SEL_SAA));
      wr_n     <= (state_d != ST_STROBE);
    end
  end

endmodule

// File: tb/tb_snd_bus_seq.sv
// Bench for snd_bus_seq: directed scenarios plus random traffic, checked every
// cycle against a transaction-timeline reference model.
module tb_snd_bus_seq;

  localparam int SETUP  = 2;
  localparam int STROBE = 8;
  localparam int HOLD   = 2;
  localparam int WARMUP = 64;
  localparam int WLEN   = SETUP + STROBE + HOLD;

  logic       fclk, rst_n;
  logic       req_valid, req_ready, req_a0;
  logic [1:0] req_sel;
  logic [7:0] req_data, bus_d;
  logic       cfg_we, cfg_saa_en, saa_enabled, bus_a0;
  logic       ym0_cs_n, ym1_cs_n, saa_cs_n, wr_n, busy;

  snd_bus_seq #(
    .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD), .WARMUP_CYC(WARMUP)
  ) dut (
    .fclk(fclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a0(req_a0), .req_data(req_data),
    .cfg_we(cfg_we), .cfg_saa_en(cfg_saa_en), .saa_enabled(saa_enabled),
    .bus_d(bus_d), .bus_a0(bus_a0),
    .ym0_cs_n(ym0_cs_n), .ym1_cs_n(ym1_cs_n), .saa_cs_n(saa_cs_n),
    .wr_n(wr_n), .busy(busy)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: the last accepted transaction and when it started.
  int         t0;
  bit         m_write;
  logic [1:0] m_sel;
  logic [7:0] m_bus_d;
  logic       m_bus_a0;
  bit         m_en;
  int         en_cyc;
  int         idle_from;

  int n_ym0, n_ym1, n_saa, n_wr, n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    t0 = -1000; m_write = 0; m_sel = 2'd0;
    m_bus_d = 8'h00; m_bus_a0 = 1'b0;
    m_en = 0; en_cyc = 0; idle_from = cyc;
  endtask

  // Apply one clock edge's worth of specification rules using pre-edge state.
  task automatic model_update();
    int  prev;
    bit  warm, issue, drop;
    prev  = cyc - 1;
    warm  = m_en && ((prev - en_cyc) >= WARMUP);
    if (req_valid && prev >= idle_from) begin
      issue = (req_sel < 2'd2) || (req_sel == 2'd2 && warm);
      drop  = (req_sel == 2'd3) || (req_sel == 2'd2 && !m_en);
      if (issue) begin
        t0 = cyc; m_write = 1; m_sel = req_sel;
        m_bus_d = req_data; m_bus_a0 = req_a0;
        idle_from = cyc + WLEN;
      end else if (drop) begin
        t0 = cyc; m_write = 0; idle_from = cyc + 1;
      end
    end
    if (cfg_we) begin
      if (cfg_saa_en && !m_en) begin m_en = 1; en_cyc = cyc; end
      else if (!cfg_saa_en) m_en = 0;
    end
  endtask

  task automatic compare_all();
    bit in_w, wr_lo;
    in_w  = m_write && cyc >= t0 && cyc <= t0 + WLEN - 1;
    wr_lo = m_write && cyc >= t0 + SETUP && cyc <= t0 + SETUP + STROBE - 1;
    chk("req_ready", 32'(req_ready), 32'(cyc == t0));
    chk("busy", 32'(busy), 32'(m_write ? in_w : (cyc == t0)));
    chk("ym0_cs_n", 32'(ym0_cs_n), 32'(!(in_w && m_sel == 2'd0)));
    chk("ym1_cs_n", 32'(ym1_cs_n), 32'(!(in_w && m_sel == 2'd1)));
    chk("saa_cs_n", 32'(saa_cs_n), 32'(!(in_w && m_sel == 2'd2)));
    chk("wr_n", 32'(wr_n), 32'(!wr_lo));
    chk("bus_d", 32'(bus_d), 32'(m_bus_d));
    chk("bus_a0", 32'(bus_a0), 32'(m_bus_a0));
    chk("saa_enabled", 32'(saa_enabled), 32'(m_en));
  endtask

  task automatic tick();
    @(posedge fclk);
    cyc++;
    model_update();
    @(negedge fclk);
    compare_all();
    if (!ym0_cs_n) n_ym0++;
    if (!ym1_cs_n) n_ym1++;
    if (!saa_cs_n) n_saa++;
    if (!wr_n)     n_wr++;
    if (busy)      n_busy++;
  endtask

  task automatic clr();
    n_ym0 = 0; n_ym1 = 0; n_saa = 0; n_wr = 0; n_busy = 0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; cfg_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ym0_cs_n", 32'(ym0_cs_n), 32'd1);
    chk("rst_ym1_cs_n", 32'(ym1_cs_n), 32'd1);
    chk("rst_saa_cs_n", 32'(saa_cs_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_saa_en", 32'(saa_enabled), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_bus_d", 32'(bus_d), 32'd0);
    repeat (2) begin @(posedge fclk); cyc++; end
    @(negedge fclk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [1:0] s, input logic a, input logic [7:0] d,
                      output int waited);
    req_valid = 1'b1; req_sel = s; req_a0 = a; req_data = d;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!req_ready && waited < 200);
    chk("accept_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic cfg(input logic en);
    cfg_we = 1'b1; cfg_saa_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    int w, r1, r2;
    rst_n = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_a0 = 1'b0;
    req_data = 8'h00; cfg_we = 1'b0; cfg_saa_en = 1'b0;
    model_reset();
    @(negedge fclk);
    do_reset();
    repeat (3) tick();

    // YM0 single write
    clr();
    send(2'd0, 1'b1, 8'h5A, w);
    chk("s1_latency", 32'(w), 32'd1);
    repeat (WLEN + 2) tick();
    chk("s1_ym0_cs_cycles", 32'(n_ym0), 32'd12);
    chk("s1_wr_cycles", 32'(n_wr), 32'd8);
    chk("s1_others", 32'(n_ym1 + n_saa), 32'd0);

    // YM1 back-to-back with valid held
    req_valid = 1'b1; req_sel = 2'd1; req_a0 = 1'b0; req_data = 8'h01;
    w = 0;
    do begin tick(); w++; end while (!req_ready && w < 50);
    r1 = cyc;
    req_data = 8'h02;
    w = 0;
    do begin tick(); w++; end while (!req_ready && w < 50);
    r2 = cyc;
    req_valid = 1'b0;
    chk("s2_b2b_spacing", 32'(r2 - r1), 32'd13);
    repeat (WLEN + 2) tick();

    // SAA while disabled is dropped
    clr();
    send(2'd2, 1'b0, 8'h77, w);
    repeat (4) tick();
    chk("s3_saa_cs", 32'(n_saa), 32'd0);
    chk("s3_wr", 32'(n_wr), 32'd0);
    chk("s3_busy_cycles", 32'(n_busy), 32'd1);

    // Enable then immediately write SAA: stalled through warm-up
    cfg(1'b1);
    clr();
    send(2'd2, 1'b1, 8'hC3, w);
    chk("s4_warmup_wait", 32'(w), 32'(WARMUP + 1));
    repeat (WLEN + 2) tick();
    chk("s4_saa_cs_cycles", 32'(n_saa), 32'd12);

    // Disable mid-strobe: write completes, next SAA write dropped
    clr();
    send(2'd2, 1'b0, 8'h3C, w);
    repeat (3) tick();
    cfg(1'b0);
    chk("s5_saa_en_off", 32'(saa_enabled), 32'd0);
    repeat (WLEN) tick();
    chk("s5_saa_cs_cycles", 32'(n_saa), 32'd12);
    chk("s5_wr_cycles", 32'(n_wr), 32'd8);
    clr();
    send(2'd2, 1'b1, 8'h99, w);
    repeat (4) tick();
    chk("s5_drop_saa_cs", 32'(n_saa), 32'd0);
    chk("s5_drop_busy", 32'(n_busy), 32'd1);

    // Reserved target dropped
    clr();
    send(2'd3, 1'b1, 8'hEE, w);
    repeat (3) tick();
    chk("rsvd_wr", 32'(n_wr), 32'd0);

    // Reset during strobe
    cfg(1'b1);
    send(2'd0, 1'b0, 8'hA5, w);
    repeat (3) tick();
    chk("s6_in_strobe", 32'(wr_n), 32'd0);
    do_reset();
    repeat (2) tick();
    send(2'd1, 1'b1, 8'h11, w);
    chk("s6_post_rst_lat", 32'(w), 32'd1);
    repeat (WLEN + 1) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (!req_valid || req_ready) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_sel   = 2'($urandom_range(0, 3));
        req_a0    = 1'($urandom_range(0, 1));
        req_data  = 8'($urandom_range(0, 255));
      end
      cfg_we     = ($urandom_range(0, 59) == 0);
      cfg_saa_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; cfg_we = 1'b0;
    repeat (WLEN + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
